pipe_hazard_ctrl: RTL

//  Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/load_use_detect.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;
  localparam int unsigned REG_W = 5;
  localparam logic ST_RUN      = 1'b0;
  localparam logic ST_MEM_WAIT = 1'b1;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT
  } state_e;
endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load sitting in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [REG_W-1:0] rd_EX,
  input  logic             RegWrite_EX,
  input  logic             DatatoReg_EX,
  output logic             hazard
);
  logic load_writes;

  assign load_writes = DatatoReg_EX && RegWrite_EX && (rd_EX != REG_ZERO);
  assign hazard = load_writes &&
                  ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                   (rs2_used_ID && (rs2_ID == rd_EX)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enable/flush sequencer: load-use stalls, EX redirects and memory waits
// with timeout, plus a saturating count of frontend stall cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [REG_W-1:0] rd_EX,
  input  logic             RegWrite_EX,
  input  logic             DatatoReg_EX,
  input  logic             redirect_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             flush_IFID,
  output logic             en_IDEX,
  output logic             flush_IDEX,
  output logic             en_EXMEM,
  output logic             flush_EXMEM,
  output logic             en_MEMWB,
  output logic             flush_MEMWB,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int unsigned WC_W = $clog2(TIMEOUT);

  state_e          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            err_nxt;
  logic            hazard;
  logic            timeout_hit;

  load_use_detect u_lud (
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .rs1_used_ID  (rs1_used_ID),
    .rs2_used_ID  (rs2_used_ID),
    .rd_EX        (rd_EX),
    .RegWrite_EX  (RegWrite_EX),
    .DatatoReg_EX (DatatoReg_EX),
    .hazard       (hazard)
  );

  assign timeout_hit = (wait_cnt == WC_W'(TIMEOUT - 1));

  // Priority mux: memory wait > redirect > load-use; everything low in reset.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = 1'b0;
    en_PC        = 1'b0;
    en_IFID      = 1'b0;
    en_IDEX      = 1'b0;
    en_EXMEM     = 1'b0;
    en_MEMWB     = 1'b0;
    flush_IFID   = 1'b0;
    flush_IDEX   = 1'b0;
    flush_EXMEM  = 1'b0;
    flush_MEMWB  = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_req_MEM && !mem_ready) begin
            flush_MEMWB  = 1'b1;
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = WC_W'(1);
          end else begin
            en_PC    = 1'b1;
            en_IFID  = 1'b1;
            en_IDEX  = 1'b1;
            en_EXMEM = 1'b1;
            en_MEMWB = 1'b1;
            if (redirect_EX) begin
              flush_IFID = 1'b1;
              flush_IDEX = 1'b1;
            end else if (hazard) begin
              en_PC      = 1'b0;
              en_IFID    = 1'b0;
              flush_IDEX = 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          flush_MEMWB = 1'b1;
          if (mem_ready || timeout_hit) begin
            en_PC        = 1'b1;
            en_IFID      = 1'b1;
            en_IDEX      = 1'b1;
            en_EXMEM     = 1'b1;
            en_MEMWB     = 1'b1;
            flush_MEMWB  = !mem_ready;
            err_nxt      = !mem_ready;
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else begin
            wait_cnt_nxt = wait_cnt + WC_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= err_nxt;
      if (!en_PC && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule
